// File: rtl/init_reset_pkg.sv
// Shared encodings for the fabric reset sequencer: FSM states and the bit
// positions of each resynchronized input inside the synchronizer vector.
package init_reset_pkg;

    typedef enum logic [2:0] {
        S_POR       = 3'd0,
        S_WAIT_INIT = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_HOLD      = 3'd3,
        S_RUN       = 3'd4
    } state_e;

    // Done-flag bit order matches INIT_DONE_REQ_MASK: {XCVR,SRAM,USRAM,DEVICE}
    localparam int DONE_DEVICE = 0;
    localparam int DONE_USRAM  = 1;
    localparam int DONE_SRAM   = 2;
    localparam int DONE_XCVR   = 3;
    localparam int SYNC_POR    = 4;
    localparam int SYNC_LOCK   = 5;
    localparam int SYNC_EXT    = 6;
    localparam int SYNC_WIDTH  = 7;

endpackage

// File: rtl/init_reset_sequencer_if.sv
// Signal bundle between the init monitor side and the fabric reset sequencer.
interface init_reset_sequencer_if;

    logic       FABRIC_POR_N;
    logic       DEVICE_INIT_DONE;
    logic       USRAM_INIT_DONE;
    logic       SRAM_INIT_DONE;
    logic       XCVR_INIT_DONE;
    logic       PLL_LOCK;
    logic       EXT_RST_N;
    logic       FABRIC_RESET_N;
    logic       INIT_TIMEOUT;
    logic [2:0] STATE;

    modport master (
        output FABRIC_POR_N, DEVICE_INIT_DONE, USRAM_INIT_DONE, SRAM_INIT_DONE,
               XCVR_INIT_DONE, PLL_LOCK, EXT_RST_N,
        input  FABRIC_RESET_N, INIT_TIMEOUT, STATE
    );

    modport slave (
        input  FABRIC_POR_N, DEVICE_INIT_DONE, USRAM_INIT_DONE, SRAM_INIT_DONE,
               XCVR_INIT_DONE, PLL_LOCK, EXT_RST_N,
        output FABRIC_RESET_N, INIT_TIMEOUT, STATE
    );

endinterface

// File: rtl/init_reset_sync.sv
// WIDTH-bit multi-flop synchronizer; synchronous reset clears every stage so
// a reset forces all resynchronized inputs low until fresh samples arrive.
module init_reset_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [STAGES-1:0][WIDTH-1:0] stages_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stages_q <= '0;
        end else begin
            stages_q[0] <= async_i;
            for (int i = 1; i < STAGES; i++) begin
                stages_q[i] <= stages_q[i-1];
            end
        end
    end

    assign sync_o = stages_q[STAGES-1];

endmodule

// File: rtl/init_reset_sequencer.sv
// Fabric reset sequencer: waits for POR, init-done flags, a filtered PLL lock
// and a minimum hold before releasing FABRIC_RESET_N; reports init timeout.
module init_reset_sequencer
    import init_reset_pkg::*;
#(
    parameter int         SYNC_STAGES        = 2,
    parameter int         LOCK_FILTER        = 8,
    parameter int         HOLD_CYCLES        = 16,
    parameter int         TIMEOUT_CYCLES     = 1000000,
    parameter logic [3:0] INIT_DONE_REQ_MASK = 4'b0001
) (
    input logic                   CLK,
    input logic                   RST,
    init_reset_sequencer_if.slave bus
);

    localparam int LW = $clog2(LOCK_FILTER + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_FILTER - 1);
    localparam logic [LW-1:0] LOCK_MAX  = LW'(LOCK_FILTER);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);

    logic [SYNC_WIDTH-1:0] async_vec;
    logic [SYNC_WIDTH-1:0] sync_vec;
    logic                  por_s;
    logic                  lock_s;
    logic                  ext_s;
    logic [3:0]            done_s;
    logic                  done_ok;

    state_e        state_q, state_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          reset_n_q, reset_n_d;
    logic          timeout_q, timeout_d;
    logic          in_hold_or_run;

    assign async_vec = {bus.EXT_RST_N, bus.PLL_LOCK, bus.FABRIC_POR_N,
                        bus.XCVR_INIT_DONE, bus.SRAM_INIT_DONE,
                        bus.USRAM_INIT_DONE, bus.DEVICE_INIT_DONE};

    init_reset_sync #(
        .WIDTH (SYNC_WIDTH),
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (CLK),
        .rst    (RST),
        .async_i(async_vec),
        .sync_o (sync_vec)
    );

    assign por_s   = sync_vec[SYNC_POR];
    assign lock_s  = sync_vec[SYNC_LOCK];
    assign ext_s   = sync_vec[SYNC_EXT];
    assign done_s  = sync_vec[DONE_XCVR:DONE_DEVICE];
    // Unrequired done bits are forced true so they may be tied low.
    assign done_ok = &(done_s | ~INIT_DONE_REQ_MASK);

    assign in_hold_or_run = (state_q == S_HOLD) || (state_q == S_RUN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_POR:       if (por_s) state_d = S_WAIT_INIT;
            S_WAIT_INIT: if (done_ok) state_d = S_WAIT_LOCK;
            S_WAIT_LOCK: if (lock_s && lock_cnt_q == LOCK_LAST) state_d = S_HOLD;
            S_HOLD:      if (ext_s && hold_cnt_q == HOLD_LAST) state_d = S_RUN;
            S_RUN:       state_d = S_RUN;
            default:     state_d = S_POR;
        endcase

        // Abort conditions override normal progress, highest priority first.
        if (!por_s) begin
            state_d = S_POR;
        end else if (!done_ok && state_q inside {S_WAIT_LOCK, S_HOLD, S_RUN}) begin
            state_d = S_WAIT_INIT;
        end else if (!lock_s && in_hold_or_run) begin
            state_d = S_WAIT_LOCK;
        end else if (!ext_s && in_hold_or_run) begin
            state_d = S_HOLD;
        end

        lock_cnt_d = '0;
        hold_cnt_d = '0;
        to_cnt_d   = '0;
        // Counters only advance while the state is held; any entry clears them.
        if (state_d == state_q) begin
            case (state_q)
                S_WAIT_INIT: to_cnt_d = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
                S_WAIT_LOCK: begin
                    if (lock_s) lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + 1'b1;
                end
                S_HOLD: begin
                    if (ext_s) hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + 1'b1;
                end
                default: ;
            endcase
        end

        timeout_d = timeout_q | (to_cnt_d == TO_MAX);
        reset_n_d = (state_d == S_RUN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_POR;
            lock_cnt_q <= '0;
            hold_cnt_q <= '0;
            to_cnt_q   <= '0;
            reset_n_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            to_cnt_q   <= to_cnt_d;
            reset_n_q  <= reset_n_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.FABRIC_RESET_N = reset_n_q;
    assign bus.INIT_TIMEOUT   = timeout_q;
    assign bus.STATE          = state_q;

endmodule

// File: tb/tb_init_reset_sequencer.sv
// Directed bench for init_reset_sequencer: edge-exact latency, lock glitch,
// external reset, abort priority, timeout flag, POR/RST aborts and done mask.
module tb_init_reset_sequencer;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   edgeNo = 0;
    int   checks = 0;
    int   errors = 0;

    init_reset_sequencer_if bus0();
    init_reset_sequencer_if bus1();

    init_reset_sequencer #(
        .TIMEOUT_CYCLES(20)
    ) dut0 (
        .CLK(CLK),
        .RST(RST),
        .bus(bus0)
    );

    // Second instance requires XCVR done as well as DEVICE done.
    init_reset_sequencer #(
        .INIT_DONE_REQ_MASK(4'b1001)
    ) dut1 (
        .CLK(CLK),
        .RST(RST),
        .bus(bus1)
    );

    always #5 CLK = ~CLK;

    // Outputs are sampled 1 time unit after each rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            edgeNo++;
        end
    endtask

    task automatic stepTo(input int target);
        while (edgeNo < target) tick(1);
    endtask

    task automatic applyStimulus(input logic por, input logic dev,
                                 input logic lock, input logic ext);
        bus0.FABRIC_POR_N     = por;
        bus0.DEVICE_INIT_DONE = dev;
        bus0.PLL_LOCK         = lock;
        bus0.EXT_RST_N        = ext;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs,
                               input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s at edge %0d: observed=%0h expected=%0h", tag, edgeNo, obs, exp);
        end
    endtask

    // Holds RST for a few edges, then releases it; edge numbering restarts at 0.
    task automatic releaseReset();
        RST = 1'b1;
        tick(3);
        checkOutput("rst_state", {5'd0, bus0.STATE}, 8'd0);
        checkOutput("rst_frn", {7'd0, bus0.FABRIC_RESET_N}, 8'd0);
        checkOutput("rst_timeout", {7'd0, bus0.INIT_TIMEOUT}, 8'd0);
        RST    = 1'b0;
        edgeNo = 0;
    endtask

    initial begin
        bus0.USRAM_INIT_DONE = 1'b0;
        bus0.SRAM_INIT_DONE  = 1'b0;
        bus0.XCVR_INIT_DONE  = 1'b0;
        bus1.FABRIC_POR_N     = 1'b1;
        bus1.DEVICE_INIT_DONE = 1'b1;
        bus1.USRAM_INIT_DONE  = 1'b0;
        bus1.SRAM_INIT_DONE   = 1'b0;
        bus1.XCVR_INIT_DONE   = 1'b0;
        bus1.PLL_LOCK         = 1'b1;
        bus1.EXT_RST_N        = 1'b1;

        $display("[TB] steady inputs: state walk and release at edge 28");
        applyStimulus(1, 1, 1, 1);
        releaseReset();
        stepTo(2);  checkOutput("t1_state_e2", {5'd0, bus0.STATE}, 8'd0);
        stepTo(3);  checkOutput("t1_state_e3", {5'd0, bus0.STATE}, 8'd1);
        stepTo(4);  checkOutput("t1_state_e4", {5'd0, bus0.STATE}, 8'd2);
        stepTo(11); checkOutput("t1_state_e11", {5'd0, bus0.STATE}, 8'd2);
        stepTo(12); checkOutput("t1_state_e12", {5'd0, bus0.STATE}, 8'd3);
        stepTo(27); checkOutput("t1_frn_e27", {7'd0, bus0.FABRIC_RESET_N}, 8'd0);
        stepTo(28); checkOutput("t1_frn_e28", {7'd0, bus0.FABRIC_RESET_N}, 8'd1);
        checkOutput("t1_state_e28", {5'd0, bus0.STATE}, 8'd4);
        checkOutput("t1_timeout", {7'd0, bus0.INIT_TIMEOUT}, 8'd0);
        checkOutput("mask_blocked_state", {5'd0, bus1.STATE}, 8'd1);

        $display("[TB] EXT_RST_N low for 10 cycles while running");
        stepTo(30); applyStimulus(1, 1, 1, 0);
        stepTo(32); checkOutput("t3_frn_e32", {7'd0, bus0.FABRIC_RESET_N}, 8'd1);
        stepTo(33); checkOutput("t3_frn_e33", {7'd0, bus0.FABRIC_RESET_N}, 8'd0);
        checkOutput("t3_state_e33", {5'd0, bus0.STATE}, 8'd3);
        stepTo(40); applyStimulus(1, 1, 1, 1);
        stepTo(57); checkOutput("t3_frn_e57", {7'd0, bus0.FABRIC_RESET_N}, 8'd0);
        stepTo(58); checkOutput("t3_frn_e58", {7'd0, bus0.FABRIC_RESET_N}, 8'd1);

        $display("[TB] lock and ext drop together while running");
        stepTo(60); applyStimulus(1, 1, 0, 0);
        stepTo(62); checkOutput("t4_state_e62", {5'd0, bus0.STATE}, 8'd4);
        stepTo(63); checkOutput("t4_state_e63", {5'd0, bus0.STATE}, 8'd2);
        checkOutput("t4_frn_e63", {7'd0, bus0.FABRIC_RESET_N}, 8'd0);
        applyStimulus(1, 1, 1, 1);
        stepTo(72); checkOutput("t4_state_e72", {5'd0, bus0.STATE}, 8'd2);
        stepTo(73); checkOutput("t4_state_e73", {5'd0, bus0.STATE}, 8'd3);
        stepTo(88); checkOutput("t4_frn_e88", {7'd0, bus0.FABRIC_RESET_N}, 8'd0);
        stepTo(89); checkOutput("t4_frn_e89", {7'd0, bus0.FABRIC_RESET_N}, 8'd1);

        $display("[TB] one-cycle PLL_LOCK glitch during lock filtering");
        applyStimulus(1, 1, 1, 1);
        releaseReset();
        stepTo(8);  applyStimulus(1, 1, 0, 1);
        stepTo(9);  applyStimulus(1, 1, 1, 1);
        stepTo(12); checkOutput("t2_state_e12", {5'd0, bus0.STATE}, 8'd2);
        stepTo(18); checkOutput("t2_state_e18", {5'd0, bus0.STATE}, 8'd2);
        stepTo(19); checkOutput("t2_state_e19", {5'd0, bus0.STATE}, 8'd3);
        stepTo(34); checkOutput("t2_frn_e34", {7'd0, bus0.FABRIC_RESET_N}, 8'd0);
        stepTo(35); checkOutput("t2_frn_e35", {7'd0, bus0.FABRIC_RESET_N}, 8'd1);

        $display("[TB] DEVICE_INIT_DONE late: timeout flag is sticky");
        applyStimulus(1, 0, 1, 1);
        releaseReset();
        stepTo(3);  checkOutput("t5_state_e3", {5'd0, bus0.STATE}, 8'd1);
        stepTo(22); checkOutput("t5_to_e22", {7'd0, bus0.INIT_TIMEOUT}, 8'd0);
        stepTo(23); checkOutput("t5_to_e23", {7'd0, bus0.INIT_TIMEOUT}, 8'd1);
        checkOutput("t5_state_e23", {5'd0, bus0.STATE}, 8'd1);
        stepTo(30); applyStimulus(1, 1, 1, 1);
        stepTo(32); checkOutput("t5_state_e32", {5'd0, bus0.STATE}, 8'd1);
        stepTo(33); checkOutput("t5_state_e33", {5'd0, bus0.STATE}, 8'd2);
        stepTo(56); checkOutput("t5_frn_e56", {7'd0, bus0.FABRIC_RESET_N}, 8'd0);
        stepTo(57); checkOutput("t5_frn_e57", {7'd0, bus0.FABRIC_RESET_N}, 8'd1);
        checkOutput("t5_to_e57", {7'd0, bus0.INIT_TIMEOUT}, 8'd1);

        $display("[TB] POR drop in hold, RST pulse in run, done mask");
        applyStimulus(1, 1, 1, 1);
        releaseReset();
        stepTo(12); checkOutput("t6_state_e12", {5'd0, bus0.STATE}, 8'd3);
        stepTo(14); applyStimulus(0, 1, 1, 1);
        stepTo(16); checkOutput("t6_state_e16", {5'd0, bus0.STATE}, 8'd3);
        stepTo(17); checkOutput("t6_state_e17", {5'd0, bus0.STATE}, 8'd0);
        checkOutput("t6_frn_e17", {7'd0, bus0.FABRIC_RESET_N}, 8'd0);
        applyStimulus(1, 1, 1, 1);
        stepTo(19); checkOutput("t6_state_e19", {5'd0, bus0.STATE}, 8'd0);
        stepTo(20); checkOutput("t6_state_e20", {5'd0, bus0.STATE}, 8'd1);
        stepTo(21); checkOutput("t6_state_e21", {5'd0, bus0.STATE}, 8'd2);
        stepTo(29); checkOutput("t6_state_e29", {5'd0, bus0.STATE}, 8'd3);
        stepTo(45); checkOutput("t6_frn_e45", {7'd0, bus0.FABRIC_RESET_N}, 8'd1);
        checkOutput("t6_state_e45", {5'd0, bus0.STATE}, 8'd4);
        stepTo(47); RST = 1'b1;
        stepTo(48); checkOutput("t6_rst_state", {5'd0, bus0.STATE}, 8'd0);
        checkOutput("t6_rst_frn", {7'd0, bus0.FABRIC_RESET_N}, 8'd0);
        RST = 1'b0;
        stepTo(75); checkOutput("t6_frn_e75", {7'd0, bus0.FABRIC_RESET_N}, 8'd0);
        stepTo(76); checkOutput("t6_frn_e76", {7'd0, bus0.FABRIC_RESET_N}, 8'd1);
        checkOutput("mask_state_e76", {5'd0, bus1.STATE}, 8'd1);
        checkOutput("mask_frn_e76", {7'd0, bus1.FABRIC_RESET_N}, 8'd0);
        bus1.XCVR_INIT_DONE = 1'b1;
        stepTo(78);  checkOutput("mask_state_e78", {5'd0, bus1.STATE}, 8'd1);
        stepTo(79);  checkOutput("mask_state_e79", {5'd0, bus1.STATE}, 8'd2);
        stepTo(102); checkOutput("mask_frn_e102", {7'd0, bus1.FABRIC_RESET_N}, 8'd0);
        stepTo(103); checkOutput("mask_frn_e103", {7'd0, bus1.FABRIC_RESET_N}, 8'd1);
        checkOutput("mask_state_e103", {5'd0, bus1.STATE}, 8'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
